// File: rtl/branch_unit_pkg.sv
// Shared defines for the branch unit: branch_op encodings, predictor reset
// value and the 2-bit saturating counter update.
package branch_unit_pkg;

    typedef enum logic [2:0] {
        OP_BEQ  = 3'b000,
        OP_BNE  = 3'b001,
        OP_BLT  = 3'b100,
        OP_BGE  = 3'b101,
        OP_BLTU = 3'b110,
        OP_BGEU = 3'b111
    } branch_op_e;

    localparam logic [1:0] BHT_INIT = 2'b01;

    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        if (taken)
            return (ctr == 2'b11) ? ctr : ctr + 2'b01;
        else
            return (ctr == 2'b00) ? ctr : ctr - 2'b01;
    endfunction

endpackage

// File: rtl/branch_cmp_core.sv
// XLEN-wide combinational branch comparator; flags codes outside the
// branch_op set as illegal.
module branch_cmp_core
    import branch_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] data_in1,
    input  logic [XLEN-1:0] data_in2,
    input  logic [2:0]      branch_op,
    output logic            taken,
    output logic            legal
);

    always_comb begin
        taken = 1'b0;
        legal = 1'b1;
        case (branch_op)
            OP_BEQ:  taken = (data_in1 == data_in2);
            OP_BNE:  taken = (data_in1 != data_in2);
            OP_BLT:  taken = ($signed(data_in1) <  $signed(data_in2));
            OP_BGE:  taken = ($signed(data_in1) >= $signed(data_in2));
            OP_BLTU: taken = (data_in1 <  data_in2);
            OP_BGEU: taken = (data_in1 >= data_in2);
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_unit.sv
// Branch resolution unit: registered compare result, 2-bit BHT predictor
// held in flops, and branch / mispredict statistics counters.
module branch_unit
    import branch_unit_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 64,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  pred_pc,
    output logic             pred_taken,
    input  logic             res_valid,
    input  logic [XLEN-1:0]  res_pc,
    input  logic [XLEN-1:0]  data_in1,
    input  logic [XLEN-1:0]  data_in2,
    input  logic [2:0]       branch_op,
    input  logic             res_pred,
    output logic             out_valid,
    output logic             branch_out,
    output logic             mispredict,
    output logic             illegal_op,
    input  logic             bht_clear,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic [1:0]       bht [BHT_DEPTH];
    logic [IDX_W-1:0] pred_idx;
    logic [IDX_W-1:0] res_idx;
    logic             taken;
    logic             legal;
    logic             do_update;
    logic             miss;
    logic             unused_pc_bits;

    assign pred_idx  = pred_pc[IDX_W+1:2];
    assign res_idx   = res_pc[IDX_W+1:2];
    assign unused_pc_bits = ^{pred_pc[XLEN-1:IDX_W+2], pred_pc[1:0],
                              res_pc[XLEN-1:IDX_W+2], res_pc[1:0]};

    // Array read is of the registered state, so a same-cycle update is not bypassed.
    assign pred_taken = bht[pred_idx][1];

    branch_cmp_core #(.XLEN(XLEN)) u_cmp (
        .data_in1  (data_in1),
        .data_in2  (data_in2),
        .branch_op (branch_op),
        .taken     (taken),
        .legal     (legal)
    );

    assign do_update = res_valid && legal;
    assign miss      = do_update && (taken != res_pred);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < BHT_DEPTH; i++)
                bht[i] <= BHT_INIT;
        end else if (bht_clear) begin
            for (int unsigned i = 0; i < BHT_DEPTH; i++)
                bht[i] <= BHT_INIT;
        end else if (do_update) begin
            bht[res_idx] <= sat_update(bht[res_idx], taken);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            branch_out  <= 1'b0;
            mispredict  <= 1'b0;
            illegal_op  <= 1'b0;
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            out_valid  <= res_valid;
            branch_out <= do_update && taken;
            mispredict <= miss;
            illegal_op <= res_valid && !legal;
            if (do_update)
                branch_cnt <= branch_cnt + CNT_W'(1);
            if (miss)
                mispred_cnt <= mispred_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit: directed corner cases plus random
// traffic against an arithmetic reference model of predictor and stats.
module tb_branch_unit;

    localparam int XLEN = 32;
    localparam int BHT  = 16;
    localparam int CW   = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [XLEN-1:0] pred_pc, res_pc, data_in1, data_in2;
    logic            pred_taken, res_valid, res_pred, bht_clear;
    logic [2:0]      branch_op;
    logic            out_valid, branch_out, mispredict, illegal_op;
    logic [CW-1:0]   branch_cnt, mispred_cnt;

    branch_unit #(.XLEN(XLEN), .BHT_DEPTH(BHT), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .pred_pc(pred_pc), .pred_taken(pred_taken),
        .res_valid(res_valid), .res_pc(res_pc), .data_in1(data_in1),
        .data_in2(data_in2), .branch_op(branch_op), .res_pred(res_pred),
        .out_valid(out_valid), .branch_out(branch_out), .mispredict(mispredict),
        .illegal_op(illegal_op), .bht_clear(bht_clear),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model state
    int ctr [BHT];
    int bcnt, mcnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int idx_of(input logic [XLEN-1:0] pc);
        return int'((pc / 4) % BHT);
    endfunction

    function automatic bit ref_eval(input logic [2:0] op, input logic [XLEN-1:0] a,
                                    input logic [XLEN-1:0] b, output bit legal);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'b0, a});
        longint ub = longint'({32'b0, b});
        legal = 1'b1;
        case (op)
            3'd0: return ua == ub;
            3'd1: return ua != ub;
            3'd4: return sa <  sb;
            3'd5: return sa >= sb;
            3'd6: return ua <  ub;
            3'd7: return ua >= ub;
            default: begin legal = 1'b0; return 1'b0; end
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < BHT; i++) ctr[i] = 1;
        bcnt = 0;
        mcnt = 0;
    endtask

    // Presents one cycle of inputs, checks the prediction before the edge
    // and the registered results after it.
    task automatic drive(input bit v, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [2:0] op, input bit pred,
                         input bit clr, input logic [XLEN-1:0] ppc);
        bit lg, tk, e_bo, e_mp, e_il;
        int i;
        res_valid = v; res_pc = pc; data_in1 = a; data_in2 = b;
        branch_op = op; res_pred = pred; bht_clear = clr; pred_pc = ppc;
        #1;
        check("pred_taken", 64'(pred_taken), 64'(ctr[idx_of(ppc)] >= 2));
        tk   = ref_eval(op, a, b, lg);
        e_bo = v && lg && tk;
        e_mp = v && lg && (tk != pred);
        e_il = v && !lg;
        @(posedge clk);
        i = idx_of(pc);
        if (clr)
            for (int k = 0; k < BHT; k++) ctr[k] = 1;
        else if (v && lg)
            ctr[i] = tk ? ((ctr[i] < 3) ? ctr[i] + 1 : 3) : ((ctr[i] > 0) ? ctr[i] - 1 : 0);
        if (v && lg) bcnt = (bcnt + 1) % (1 << CW);
        if (e_mp)    mcnt = (mcnt + 1) % (1 << CW);
        #1;
        check("out_valid",   64'(out_valid),   64'(v));
        check("branch_out",  64'(branch_out),  64'(e_bo));
        check("mispredict",  64'(mispredict),  64'(e_mp));
        check("illegal_op",  64'(illegal_op),  64'(e_il));
        check("branch_cnt",  64'(branch_cnt),  64'(bcnt));
        check("mispred_cnt", 64'(mispred_cnt), 64'(mcnt));
    endtask

    task automatic idle(input logic [XLEN-1:0] ppc);
        drive(1'b0, '0, '0, '0, 3'd0, 1'b0, 1'b0, ppc);
    endtask

    initial begin
        logic [XLEN-1:0] a, b, pc;
        logic [2:0] ops [6];
        bit exp_bo [6];
        ops[0] = 3'd0; ops[1] = 3'd1; ops[2] = 3'd4;
        ops[3] = 3'd5; ops[4] = 3'd6; ops[5] = 3'd7;
        exp_bo[0] = 1; exp_bo[1] = 0; exp_bo[2] = 0;
        exp_bo[3] = 1; exp_bo[4] = 0; exp_bo[5] = 1;

        rst = 1'b1; res_valid = 0; res_pc = '0; data_in1 = '0; data_in2 = '0;
        branch_op = '0; res_pred = 0; bht_clear = 0; pred_pc = '0;
        model_reset();
        #12;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_branch_cnt", 64'(branch_cnt), 64'(0));
        for (int k = 0; k < BHT; k++) begin
            pred_pc = XLEN'(k * 4);
            #1;
            check("rst_pred", 64'(pred_taken), 64'(0));
        end
        @(negedge clk);
        rst = 1'b0;

        // signed vs unsigned compare
        drive(1, 32'h40, 32'hff786510, 32'h1096bc81, 3'd4, 0, 0, 32'h40);
        check("signed_blt", 64'(branch_out), 64'(1));
        check("signed_mp_cnt", 64'(mispred_cnt), 64'(1));
        drive(1, 32'h40, 32'hff786510, 32'h1096bc81, 3'd6, 0, 0, 32'h40);
        check("unsigned_bltu", 64'(branch_out), 64'(0));

        // equal operands across all ops; cleanup with reset first
        rst = 1'b1; #1; rst = 1'b0; model_reset();
        for (int k = 0; k < 6; k++) begin
            drive(1, 32'h80, 32'h12345678, 32'h12345678, ops[k], 0, 0, 32'h80);
            check("equal_op", 64'(branch_out), 64'(exp_bo[k]));
        end
        check("equal_cnt", 64'(branch_cnt), 64'(6));

        // saturation at PC 0x100
        for (int k = 0; k < 3; k++)
            drive(1, 32'h100, 32'h5, 32'h5, 3'd0, 0, 0, 32'h100);
        check("sat_ctr", 64'(ctr[idx_of(32'h100)]), 64'(3));
        idle(32'h100);
        check("sat_pred_hi", 64'(pred_taken), 64'(1));
        drive(1, 32'h100, 32'h5, 32'h6, 3'd0, 1, 0, 32'h100);
        drive(1, 32'h100, 32'h5, 32'h6, 3'd0, 1, 0, 32'h100);
        idle(32'h100);
        check("sat_pred_lo", 64'(pred_taken), 64'(0));

        // aliasing then clear with a same-cycle update
        drive(1, 32'h100 + 4 * BHT, 32'h1, 32'h2, 3'd1, 1, 0, 32'h100);
        drive(1, 32'h100 + 4 * BHT, 32'h1, 32'h2, 3'd1, 1, 0, 32'h100);
        idle(32'h100);
        check("alias_pred", 64'(pred_taken), 64'(1));
        drive(1, 32'h100, 32'h1, 32'h2, 3'd1, 1, 1, 32'h100);
        idle(32'h100);
        check("clear_pred", 64'(pred_taken), 64'(0));

        // illegal op leaves predictor and stats alone
        drive(1, 32'h100, 32'h9, 32'h9, 3'b010, 0, 0, 32'h100);
        check("illegal_flag", 64'(illegal_op), 64'(1));
        idle(32'h100);

        // asynchronous reset while a result is valid
        drive(1, 32'h20, 32'h3, 32'h3, 3'd0, 0, 0, 32'h20);
        check("pre_rst_valid", 64'(out_valid), 64'(1));
        rst = 1'b1;
        #1;
        check("async_valid",  64'(out_valid),  64'(0));
        check("async_bo",     64'(branch_out), 64'(0));
        check("async_cnt",    64'(branch_cnt), 64'(0));
        check("async_pred",   64'(pred_taken), 64'(0));
        model_reset();
        res_valid = 0;
        @(negedge clk);
        rst = 1'b0;

        // statistics wrap at 2^CNT_W
        for (int k = 0; k < 17; k++)
            drive(1, XLEN'(k * 4), 32'h7, 32'h7, 3'd5, 1, 0, '0);
        check("wrap_cnt", 64'(branch_cnt), 64'(1));

        // random traffic
        for (int n = 0; n < 400; n++) begin
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : XLEN'($urandom);
            pc = XLEN'($urandom_range(0, 4 * BHT * 2 - 1));
            drive($urandom_range(0, 9) < 8, pc, a, b, 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 19) == 0,
                  XLEN'($urandom_range(0, 4 * BHT - 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_unit.md
BRANCH_UNIT -- requirements
Module: branch_unit

Interface
REQ-001 Parameter XLEN, default 32: operand width in bits (8..64).
REQ-002 Parameter BHT_DEPTH, default 64: number of 2-bit predictor counters; power of two, at least 4.
REQ-003 Parameter CNT_W, default 32: width of the statistics counters.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 pred_pc  input  XLEN  fetch PC to look up.
REQ-007 pred_taken  output  1  combinational prediction for pred_pc.
REQ-008 res_valid  input  1  a branch is presented for resolution this cycle.
REQ-009 res_pc  input  XLEN  PC of the branch being resolved.
REQ-010 data_in1, data_in2  input  XLEN each  rs1 and rs2 operands.
REQ-011 branch_op  input  3  BEQ/BNE/BLT/BGE/BLTU/BGEU code from the shared defines.
REQ-012 res_pred  input  1  prediction that was issued for this branch.
REQ-013 out_valid  output  1  registered result valid.
REQ-014 branch_out  output  1  registered taken decision.
REQ-015 mispredict  output  1  registered flag: branch_out differs from res_pred.
REQ-016 illegal_op  output  1  registered flag: branch_op was not a legal code.
REQ-017 bht_clear  input  1  synchronous clear of all predictor counters.
REQ-018 branch_cnt, mispred_cnt  output  CNT_W each  statistics counters.

Function
REQ-019 Index: idx = pc[log2(BHT_DEPTH)+1:2]; bits [1:0] are ignored.
REQ-020 pred_taken equals the MSB of counter[idx(pred_pc)], with no bypass from a same-cycle update (the pre-update value is used).
REQ-021 Compare: BEQ a==b; BNE a!=b; BLT signed a<b; BGE signed a>=b; BLTU unsigned a<b; BGEU unsigned a>=b, all over the full XLEN bits.
REQ-022 Latency is 1 cycle: res_valid at edge N gives out_valid=1 and the result outputs during cycle N+1; out_valid=0 in a cycle after res_valid=0.
REQ-023 When out_valid=0, branch_out, mispredict and illegal_op are held at 0.
REQ-024 Illegal branch_op: branch_out=0, mispredict=0, illegal_op=1; no counter update and no statistics update.
REQ-025 Counter update on a legal res_valid: taken increments, saturating at 3; not-taken decrements, saturating at 0.
REQ-026 Back-to-back branches to the same index: each update uses the value already written by the previous update, so no update is lost.
REQ-027 bht_clear sets all counters to 2'b01 at the next edge, overriding a same-cycle update.
REQ-028 bht_clear does not affect the result pipeline or the statistics counters.
REQ-029 branch_cnt increments on every legal resolution; mispred_cnt increments when mispredict is set.
REQ-030 Both statistics counters wrap modulo 2^CNT_W.

Reset
REQ-031 On rst: every counter is 2'b01; out_valid, branch_out, mispredict and illegal_op are 0; branch_cnt and mispred_cnt are 0.
REQ-032 Reset takes effect immediately and asynchronously, including mid-operation; a resolution in flight is discarded.
REQ-033 The first rising edge after rst deasserts processes inputs normally.

Structure
REQ-034 The branch_op codes (BEQ..BGEU) stay in the shared defines header.
REQ-035 The counter reset value 2'b01 is defined in the shared defines header.
REQ-036 The XLEN-parametrised combinational comparator is the one sub-module, branch_cmp_core.
REQ-037 The BHT is a flop array inside branch_unit, not a memory macro.

Verification
REQ-038 Signed vs unsigned: a=ff786510, b=1096bc81, BLT, res_pred=0 -> next cycle branch_out=1, mispredict=1, mispred_cnt=1; the same operands with BLTU -> branch_out=0.
REQ-039 Equal operands: a=b=12345678; BEQ/BNE/BLT/BGE/BLTU/BGEU -> branch_out 1/0/0/1/0/1, branch_cnt=6.
REQ-040 Saturation: three taken resolutions at PC 0x100 -> pred_taken(0x100)=1 after the second; the counter stays at 3 after the third; then two not-taken -> pred_taken=0.
REQ-041 Aliasing and clear: PC 0x100 and 0x100+4*BHT_DEPTH share a counter; asserting bht_clear together with res_valid -> pred_taken=0 afterwards.
REQ-042 Illegal and reset: branch_op=3'b010 -> illegal_op=1 and counters unchanged; rst pulsed while out_valid=1 -> all outputs 0 immediately.
REQ-043 Wrap: with CNT_W=4, 17 legal resolutions -> branch_cnt=1.
